// File: rtl/lsu_split_pkg.sv
// Shared encodings for the load/store unit: access info codes, FSM states, size helper.
package lsu_split_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LD  = 3'd3,
    LBU = 3'd4,
    LHU = 3'd5,
    LWU = 3'd6
  } lsu_info_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  function automatic logic [3:0] size_bytes(input logic [2:0] info);
    return 4'd1 << info[1:0];
  endfunction

endpackage

// File: rtl/lsu_split_fmt.sv
// Load extractor: shifts the merged {hi,lo} bus words down by the byte offset,
// keeps the access size and sign- or zero-extends to the register width.
module lsu_fmt
  import lsu_split_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [2*DATA_W-1:0] word_i,
  input  logic [2:0]          off_i,
  input  logic [2:0]          info_i,
  output logic [DATA_W-1:0]   result_o
);

  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] msk;
  logic [7:0]        nb;
  logic              sgn;

  always_comb begin
    sh  = DATA_W'(word_i >> {off_i, 3'b000});
    nb  = 8'd8 << info_i[1:0];
    // a shift by the full width yields zero, so a full-width load keeps every bit
    msk = ~({DATA_W{1'b1}} << nb);
    case (info_i[1:0])
      2'd0:    sgn = sh[7];
      2'd1:    sgn = sh[15];
      2'd2:    sgn = sh[31];
      default: sgn = sh[DATA_W-1];
    endcase
    sgn      = sgn & ~info_i[2];
    result_o = (sh & msk) | ({DATA_W{sgn}} & ~msk);
  end

endmodule

// File: rtl/lsu_split.sv
// Load/store unit with a registered bus request; accesses crossing a bus-word
// boundary are issued as two beats and merged before formatting.
module lsu_split
  import lsu_split_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 64,
  parameter int MMIO_BIT = 31,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [2:0]          req_info_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  output logic                dreq_valid_o,
  output logic [ADDR_W-1:0]   dreq_addr_o,
  output logic [2:0]          dreq_size_o,
  output logic [DATA_W/8-1:0] dreq_strobe_o,
  output logic [DATA_W-1:0]   dreq_data_o,
  input  logic                dresp_data_ok_i,
  input  logic [DATA_W-1:0]   dresp_data_i,
  output logic                resp_valid_o,
  output logic [DATA_W-1:0]   resp_data_o,
  output logic                resp_misalign_o,
  output logic                skip_o,
  output logic                stall_req_o
);

  localparam int B  = DATA_W / 8;
  localparam int OW = $clog2(B);

  lsu_state_e        state_q;
  logic              we_q, skip_q, mis_q, cross_q;
  logic [2:0]        info_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, lo_q, hi_q;

  logic [2:0]          off_in, off;
  logic                illegal_in, cross_in, beat1;
  logic [2*B-1:0]      strb_w;
  logic [2*DATA_W-1:0] data_w;
  logic [ADDR_W-1:0]   base;
  logic [DATA_W-1:0]   fmt_res;

  function automatic logic crosses(input logic [2:0] o, input logic [2:0] info);
    return ({2'b00, o} + {1'b0, size_bytes(info)}) > 5'(B);
  endfunction

  assign off_in     = 3'(req_addr_i[OW-1:0]);
  assign off        = 3'(addr_q[OW-1:0]);
  assign illegal_in = (req_info_i == 3'd7) ||
                      ((DATA_W == 32) && (req_info_i == LD || req_info_i == LWU));
  assign cross_in   = crosses(off_in, req_info_i);

  // Rejected accesses still pass through BEAT0 with the bus gated off, so the
  // reply arrives with the same latency as a single-beat hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      info_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      skip_q  <= 1'b0;
      mis_q   <= 1'b0;
      cross_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          we_q    <= req_we_i;
          info_q  <= req_info_i;
          addr_q  <= req_addr_i;
          wdata_q <= req_wdata_i;
          skip_q  <= ~req_addr_i[MMIO_BIT];
          mis_q   <= illegal_in || (cross_in && (SPLIT_EN == 1'b0));
          cross_q <= cross_in;
          lo_q    <= '0;
          hi_q    <= '0;
          state_q <= BEAT0;
        end
        BEAT0: begin
          if (mis_q) state_q <= RESP;
          else if (dresp_data_ok_i) begin
            lo_q    <= dresp_data_i;
            state_q <= cross_q ? BEAT1 : RESP;
          end
        end
        BEAT1: if (dresp_data_ok_i) begin
          hi_q    <= dresp_data_i;
          state_q <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign beat1  = (state_q == BEAT1);
  assign strb_w = ~({(2*B){1'b1}} << size_bytes(info_q)) << off;
  assign data_w = {{DATA_W{1'b0}}, wdata_q} << {off, 3'b000};
  assign base   = addr_q & ~ADDR_W'(B - 1);

  assign req_ready_o   = (state_q == IDLE);
  assign stall_req_o   = (state_q != IDLE);
  assign dreq_valid_o  = ((state_q == BEAT0) && !mis_q) || beat1;
  assign dreq_addr_o   = dreq_valid_o ? base + (beat1 ? ADDR_W'(B) : '0) : '0;
  assign dreq_size_o   = dreq_valid_o ? {1'b0, info_q[1:0]} : 3'd0;
  assign dreq_strobe_o = (dreq_valid_o && we_q) ? (beat1 ? strb_w[2*B-1:B] : strb_w[B-1:0]) : '0;
  assign dreq_data_o   = dreq_valid_o ? (beat1 ? data_w[2*DATA_W-1:DATA_W] : data_w[DATA_W-1:0]) : '0;

  lsu_fmt #(.DATA_W(DATA_W)) u_fmt (
    .word_i   ({hi_q, lo_q}),
    .off_i    (off),
    .info_i   (info_q),
    .result_o (fmt_res)
  );

  assign resp_valid_o    = (state_q == RESP);
  assign resp_misalign_o = resp_valid_o && mis_q;
  assign skip_o          = resp_valid_o && skip_q;
  assign resp_data_o     = (resp_valid_o && !we_q && !mis_q) ? fmt_res : '0;

endmodule
